// File: rtl/compressor_pkg.sv
// Shared constants and payload type for the pipelined 4:2 compressor row.
// Optional final adder is controlled by the COMPRESSOR_FINAL_ADD_EN macro.
package compressor_pkg;

    localparam int COMP_WIDTH    = 8;
    localparam int COMP_RESULT_W = COMP_WIDTH + 2;

    typedef struct packed {
        logic [COMP_WIDTH-1:0] sum;
        logic [COMP_WIDTH-1:0] carry;
        logic                  cout;
    } comp_payload_t;

    function automatic int comp_result_w(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/compressor_4to2_cell.sv
// One 4:2 compressor column: two chained full adders, combinational.
// co feeds the next column's ci; carry leaves the row with weight 2^(i+1).
module compressor_4to2_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic ci,
    output logic s,
    output logic co,
    output logic carry
);

    logic s1;

    full_adder u_fa1 (
        .a  (a),
        .b  (b),
        .c  (c),
        .s  (s1),
        .co (co)
    );

    full_adder u_fa2 (
        .a  (s1),
        .b  (d),
        .c  (ci),
        .s  (s),
        .co (carry)
    );

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder: s = a^b^c, co = majority(a,b,c). Purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/compressor_4to2_pipe.sv
// WIDTH-bit 4:2 compressor row with two-stage valid/ready pipeline, 2-cycle latency.
// COMPRESSOR_FINAL_ADD_EN adds a registered binary result in stage 2; otherwise result_o is 0.
module compressor_4to2_pipe
    import compressor_pkg::*;
#(
    parameter int WIDTH = COMP_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  x1_i,
    input  logic [WIDTH-1:0]                  x2_i,
    input  logic [WIDTH-1:0]                  x3_i,
    input  logic [WIDTH-1:0]                  x4_i,
    input  logic                              cin_i,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  sum_o,
    output logic [WIDTH-1:0]                  carry_o,
    output logic                              cout_o,
    output logic [comp_result_w(WIDTH)-1:0]   result_o
);

    localparam int RW = comp_result_w(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] carry;
        logic             cout;
    } stage_t;

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;
    logic [WIDTH-1:0] co_c;
    logic [WIDTH-1:0] ci_c;

    // Inter-column chain only through FA1 carries; FA2 carries never ripple.
    assign ci_c = {co_c[WIDTH-2:0], cin_i};

    for (genvar i = 0; i < WIDTH; i++) begin : g_col
        compressor_4to2_cell u_cell (
            .a     (x1_i[i]),
            .b     (x2_i[i]),
            .c     (x3_i[i]),
            .d     (x4_i[i]),
            .ci    (ci_c[i]),
            .s     (sum_c[i]),
            .co    (co_c[i]),
            .carry (carry_c[i])
        );
    end

    stage_t s1_q, s1_d, s2_q, s2_d;
    logic   s1_valid_q, s1_valid_d;
    logic   out_valid_q, out_valid_d;
    logic   s1_load, s2_load;

    always_comb begin
        s2_load     = s1_valid_q && (!out_valid_q || out_ready);
        in_ready    = !s1_valid_q || s2_load;
        s1_load     = in_valid && in_ready;
        s1_d        = s1_q;
        s2_d        = s2_q;
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;

        if (s1_load) begin
            s1_d.sum   = sum_c;
            s1_d.carry = carry_c;
            s1_d.cout  = co_c[WIDTH-1];
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_d        = s1_q;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef COMPRESSOR_FINAL_ADD_EN
    logic [RW-1:0] result_q, result_d;

    always_comb begin
        result_d = result_q;
        if (s2_load) begin
            result_d = RW'(s1_q.sum) + (RW'(s1_q.carry) << 1) + (RW'(s1_q.cout) << WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result_o = result_q;
`else
    assign result_o = {RW{1'b0}};
`endif

    assign out_valid = out_valid_q;
    assign sum_o     = s2_q.sum;
    assign carry_o   = s2_q.carry;
    assign cout_o    = s2_q.cout;

endmodule
